wifi_rx_qam16_demapper: RTL
===========================

WIFI_RX_QAM16_DEMAPPER -- requirements
Module: wifi_rx_qam16_demapper

Interface
REQ-001 Parameter W, default 8: signed width of I and Q samples.
REQ-002 Parameter THR, default 32: inner/outer decision threshold magnitude, must satisfy 0 < THR < 2^(W-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  I/Q sample pair present this cycle.
REQ-006 i_in  input  W  signed two's-complement in-phase sample.
REQ-007 q_in  input  W  signed two's-complement quadrature sample.
REQ-008 ready_out  output  1  registered; block accepts a sample this cycle.
REQ-009 valid_out  output  1  registered; data_out carries a demapped symbol.
REQ-010 data_out  output  4  registered hard-decision bits {b0,b1,b2,b3}, b0 at bit 3, b3 at bit 0.

Function
REQ-011 A sample is accepted at a rising edge only when valid_in=1 and ready_out=1; valid_in while ready_out=0 is ignored and the sample is dropped.
REQ-012 Slicing of an accepted sample: b0=(i_in>=0), b1=(|i_in|<THR), b2=(q_in>=0), b3=(|q_in|<THR); Gray mapping -3->00, -1->01, +1->11, +3->10 per axis.
REQ-013 |x| is computed in W+1 bits so that x=-2^(W-1) gives magnitude 2^(W-1) (outer level); x=0 counts as non-negative.
REQ-014 Sliced 4-bit words go into a 2-entry FIFO in acceptance order; no word is lost or reordered.
REQ-015 The output stage has states IDLE and HOLD with a 2-bit phase counter.
REQ-016 IDLE: valid_out=0, data_out=0; if FIFO is non-empty at an edge, go to HOLD, load data_out from the FIFO head, set phase=0, valid_out=1.
REQ-017 HOLD: data_out and valid_out=1 stay constant for exactly 4 consecutive cycles (phase 0..3); phase increments each cycle.
REQ-018 At the edge ending phase 3 the head entry is popped; if another entry exists (including one written at that same edge) HOLD reloads it with phase=0 and valid_out stays 1 without a gap, otherwise go to IDLE with valid_out=0 and data_out=0.
REQ-019 Latency: sample accepted at edge k with FIFO empty and state IDLE -> valid_out=1 with its data after edge k+1.
REQ-020 ready_out after each edge = 1 if FIFO occupancy after that edge is less than 2, else 0; simultaneous push and pop at occupancy 1 or 2 is permitted and leaves occupancy consistent.
REQ-021 Sustained throughput is one sample per 4 cycles; upstream stalls via ready_out, and valid_out never deasserts between back-to-back symbols.

Reset
REQ-022 reset=0 asynchronously forces valid_out=0, data_out=4'b0000, ready_out=0, FIFO empty, state IDLE, phase=0.
REQ-023 First rising edge after reset release sets ready_out=1; no sample is accepted on that edge.
REQ-024 Reset asserted mid-HOLD discards the current symbol and all FIFO contents; no partial symbol is emitted after release.

Verification
REQ-025 Reset then I=+48, Q=-16 accepted once -> data_out=4'b1001, valid_out=1 for exactly 4 cycles starting one cycle after acceptance, then 0/0000.
REQ-026 Boundary slicing: (I=-32,Q=+31) -> 4'b0011; (I=0,Q=-128) -> 4'b1100; (I=-1,Q=+127) -> 4'b0110.
REQ-027 valid_in held at 1 with samples A=(+48,+48) 4'b1010, B=(-16,-48) 4'b0100, C=(+16,+16) 4'b1111 -> ready_out drops after the FIFO fills; output is A,A,A,A,B,B,B,B,C,C,C,C with valid_out continuously 1 for 12 cycles; no sample lost.
REQ-028 valid_in=1 while ready_out=0 with sample (-48,-48) -> that sample never appears on data_out.
REQ-029 Reset asserted during phase 2 of a symbol with one more queued -> valid_out=0, data_out=0000 immediately; after release, with no input, valid_out stays 0.
REQ-030 New sample accepted on the same edge that pops the last entry -> next symbol starts at the following cycle with valid_out unbroken.

Source files
------------

// File: rtl/wifi_rx_qam16_demapper_if.sv
// wifi_rx_qam16_demapper_if: sample-in / symbol-out bundle for the 16-QAM demapper.
// Rev 1.0
`default_nettype none

interface wifi_rx_qam16_demapper_if #(
  parameter int W = 8
);
  logic                valid_in;
  logic signed [W-1:0] i_in;
  logic signed [W-1:0] q_in;
  logic                ready_out;
  logic                valid_out;
  logic [3:0]          data_out;

  modport master (
    output valid_in, i_in, q_in,
    input  ready_out, valid_out, data_out
  );

  modport slave (
    input  valid_in, i_in, q_in,
    output ready_out, valid_out, data_out
  );
endinterface

`default_nettype wire

// File: rtl/wifi_rx_qam16_demapper.sv
// wifi_rx_qam16_demapper: 16-QAM hard-decision slicer, 2-deep FIFO, each symbol held 4 cycles.
// Rev 1.0
`default_nettype none

module wifi_rx_qam16_demapper #(
  parameter int W   = 8,
  parameter int THR = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  wifi_rx_qam16_demapper_if.slave        bus
);

  localparam logic [W:0] THR_EXT = (W+1)'(THR);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t     state_q;
  logic [1:0] phase_q;
  logic [3:0] mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic       ready_q;
  logic       valid_q;
  logic [3:0] data_q;

  logic [3:0] w_word;
  logic       w_push;
  logic       w_pop;
  logic [1:0] count_d;

  // Magnitude is formed one bit wider so the most negative sample maps to the outer level.
  function automatic logic [1:0] slice_axis(input logic [W-1:0] x);
    logic [W:0] x_ext;
    logic [W:0] mag;
    x_ext = {x[W-1], x};
    mag   = x[W-1] ? (~x_ext + (W+1)'(1)) : x_ext;
    return {~x[W-1], (mag < THR_EXT)};
  endfunction

  assign w_word  = {slice_axis(bus.i_in), slice_axis(bus.q_in)};
  assign w_push  = bus.valid_in & ready_q;
  assign w_pop   = (state_q == S_HOLD) && (phase_q == 2'd3);
  assign count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      phase_q  <= 2'd0;
      mem_q[0] <= 4'd0;
      mem_q[1] <= 4'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 4'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);

      case (state_q)
        S_IDLE: begin
          phase_q <= 2'd0;
          if (count_q != 2'd0) begin
            state_q <= S_HOLD;
            data_q  <= mem_q[rd_ptr_q];
            valid_q <= 1'b1;
          end else begin
            data_q  <= 4'd0;
            valid_q <= 1'b0;
          end
        end
        S_HOLD: begin
          phase_q <= phase_q + 2'd1;
          // The head stays in the FIFO while on display; the successor may be
          // the second entry or a word being written on this very edge.
          if (w_pop) begin
            phase_q <= 2'd0;
            if (count_q == 2'd2) begin
              data_q <= mem_q[~rd_ptr_q];
            end else if (w_push) begin
              data_q <= w_word;
            end else begin
              state_q <= S_IDLE;
              data_q  <= 4'd0;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          phase_q <= 2'd0;
          data_q  <= 4'd0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;

endmodule

`default_nettype wire
